// File: rtl/maze_pkg.sv
// Shared definitions for the maze level store.
// Holds the wall bit indices, the move direction encoding, the per-level
// geometry record and the level ROM contents.
// Ports: none (package).
package maze_pkg;

    // Wall bit positions inside a 4-bit cell word {T,B,L,R}.
    localparam int WALL_T = 3;
    localparam int WALL_B = 2;
    localparam int WALL_L = 1;
    localparam int WALL_R = 0;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef struct packed {
        logic [9:0] tile_w;
        logic [9:0] tile_h;
        logic [4:0] num_rows;
        logic [4:0] num_cols;
        logic [9:0] wall_margin;
    } level_geo_t;

    // Wall bit that blocks a move in the given direction.
    function automatic logic [1:0] wall_idx(input dir_t dir);
        case (dir)
            DIR_UP:   return 2'(WALL_T);
            DIR_DOWN: return 2'(WALL_B);
            DIR_LEFT: return 2'(WALL_L);
            default:  return 2'(WALL_R);
        endcase
    endfunction

    // Per-level geometry table.
    function automatic level_geo_t geo_of(input int lvl);
        level_geo_t g;
        case (lvl)
            1: begin
                g.tile_w = 10'd20; g.tile_h = 10'd30;
                g.num_rows = 5'd8; g.num_cols = 5'd16; g.wall_margin = 10'd3;
            end
            2: begin
                g.tile_w = 10'd32; g.tile_h = 10'd24;
                g.num_rows = 5'd5; g.num_cols = 5'd10; g.wall_margin = 10'd4;
            end
            3: begin
                g.tile_w = 10'd26; g.tile_h = 10'd20;
                g.num_rows = 5'd6; g.num_cols = 5'd12; g.wall_margin = 10'd1;
            end
            default: begin
                g.tile_w = 10'd40; g.tile_h = 10'd40;
                g.num_rows = 5'd4; g.num_cols = 5'd6; g.wall_margin = 10'd2;
            end
        endcase
        return g;
    endfunction

    // Level ROM contents for an in-level cell. The outer frame is walled
    // except for gaps in the top edge on odd columns; interior walls follow
    // a per-level diagonal pattern so each level differs.
    function automatic logic [3:0] rom_cell(input int lvl, input int row, input int col);
        level_geo_t g;
        logic t, b, l, r;
        g = geo_of(lvl);
        t = (row == 0) && (col % 2 == 0);
        b = (row == int'(g.num_rows) - 1) || ((row + col + lvl) % 3 == 0);
        l = (col == 0);
        r = (col == int'(g.num_cols) - 1) || ((2 * row + col + lvl) % 5 == 0);
        return {t, b, l, r};
    endfunction

endpackage

// File: rtl/maze_level_store_if.sv
// Query/response channel between the movement/render logic and the store.
// master: drives q_valid/q_row/q_col/q_dir, receives q_ready and responses.
// slave : the store; accepts queries, returns r_valid/r_walls/r_move_ok.
interface maze_level_store_if #(
    parameter int ROW_W = 3,
    parameter int COL_W = 4
);
    logic             q_valid;
    logic             q_ready;
    logic [ROW_W-1:0] q_row;
    logic [COL_W-1:0] q_col;
    logic [1:0]       q_dir;
    logic             r_valid;
    logic [3:0]       r_walls;
    logic             r_move_ok;

    modport master (
        output q_valid, q_row, q_col, q_dir,
        input  q_ready, r_valid, r_walls, r_move_ok
    );

    modport slave (
        input  q_valid, q_row, q_col, q_dir,
        output q_ready, r_valid, r_walls, r_move_ok
    );
endinterface

// File: rtl/maze_cell_ram.sv
// Single-port synchronous RAM for the active wall map, one 4-bit cell per word.
// Ports: clk; we/wdata write at addr; re registers mem[addr] into rdata.
module maze_cell_ram #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        wdata,
    output logic [3:0]        rdata
);
    logic [3:0] mem [DEPTH];

    // NOTE: the array has no reset; its contents are only trusted after a load.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/maze_level_store.sv
// Multi-level maze map store. A load copies the selected ROM level into the
// active map RAM, one cell per cycle; queries return the cell walls and the
// legality of a move one cycle after acceptance.
// Ports: clk, reset (sync, active-high); load_req/level_sel start a load;
// load_busy/load_done/load_err/level_valid report load status; qif carries
// query/response; tile_w, tile_h, wall_margin, num_rows, num_cols give the
// active level geometry.
module maze_level_store
    import maze_pkg::*;
#(
    parameter int         NUM_LEVELS = 4,
    parameter int         MAX_ROWS   = 8,
    parameter int         MAX_COLS   = 16,
    parameter logic [3:0] OOB_WALLS  = 4'b1111,
    localparam int        LSEL_W     = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    localparam int        CELLS      = MAX_ROWS * MAX_COLS,
    localparam int        ADDR_W     = $clog2(CELLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic [LSEL_W-1:0] level_sel,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic              level_valid,
    maze_level_store_if.slave qif,
    output logic [9:0]        tile_w,
    output logic [9:0]        tile_h,
    output logic [9:0]        wall_margin,
    output logic [4:0]        num_rows,
    output logic [4:0]        num_cols
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] cnt;
    logic [LSEL_W-1:0] lvl;
    level_geo_t        geo, lvl_geo;
    logic              sel_ok, last_cell, accept;
    int                ld_row, ld_col;
    logic [3:0]        wr_walls, ram_q;
    logic              q_oob, q_tgt_ok;
    logic              r_valid_q, oob_q, tgt_ok_q;
    dir_t              dir_q;

    assign sel_ok    = 32'(level_sel) < NUM_LEVELS;
    assign last_cell = (cnt == ADDR_W'(CELLS - 1));
    assign accept    = qif.q_valid && qif.q_ready;
    assign lvl_geo   = geo_of(int'(lvl));

    // NOTE: state and datapath registers use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of a combinational block is defaulted first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_req && sel_ok) state_next = LOAD;
            LOAD:    if (last_cell) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign load_busy   = (state == LOAD);
    assign load_done   = (state == DONE);
    assign qif.q_ready = (state == IDLE) && !load_req;

    // Cells beyond the level's dimensions are stored as solid walls.
    always_comb begin
        ld_row   = int'(cnt) / MAX_COLS;
        ld_col   = int'(cnt) % MAX_COLS;
        wr_walls = OOB_WALLS;
        if (ld_row < int'(lvl_geo.num_rows) && ld_col < int'(lvl_geo.num_cols))
            wr_walls = rom_cell(int'(lvl), ld_row, ld_col);
    end

    // Bounds and target-cell checks are computed at acceptance and carried
    // alongside the RAM read so the response is aligned with the read data.
    always_comb begin
        q_oob    = !level_valid
                 || int'(qif.q_row) >= int'(geo.num_rows)
                 || int'(qif.q_col) >= int'(geo.num_cols);
        q_tgt_ok = 1'b0;
        case (dir_t'(qif.q_dir))
            DIR_UP:    q_tgt_ok = int'(qif.q_row) > 0;
            DIR_DOWN:  q_tgt_ok = int'(qif.q_row) + 1 < int'(geo.num_rows);
            DIR_LEFT:  q_tgt_ok = int'(qif.q_col) > 0;
            DIR_RIGHT: q_tgt_ok = int'(qif.q_col) + 1 < int'(geo.num_cols);
            default:   q_tgt_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            lvl         <= '0;
            geo         <= '0;
            level_valid <= 1'b0;
            load_err    <= 1'b0;
            r_valid_q   <= 1'b0;
            oob_q       <= 1'b1;
            tgt_ok_q    <= 1'b0;
            dir_q       <= DIR_UP;
        end else begin
            load_err  <= (state == IDLE) && load_req && !sel_ok;
            r_valid_q <= accept;
            if (state == IDLE && load_req && sel_ok) begin
                lvl         <= level_sel;
                cnt         <= '0;
                level_valid <= 1'b0;
            end
            if (state == LOAD) begin
                cnt <= cnt + 1'b1;
                if (last_cell) begin
                    geo         <= lvl_geo;
                    level_valid <= 1'b1;
                end
            end
            if (accept) begin
                oob_q    <= q_oob;
                tgt_ok_q <= q_tgt_ok;
                dir_q    <= dir_t'(qif.q_dir);
            end
        end
    end

    maze_cell_ram #(.DEPTH(CELLS), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (state == LOAD),
        .re    (accept),
        .addr  ((state == LOAD) ? cnt
                                : ADDR_W'(int'(qif.q_row) * MAX_COLS + int'(qif.q_col))),
        .wdata (wr_walls),
        .rdata (ram_q)
    );

    assign qif.r_valid   = r_valid_q;
    assign qif.r_walls   = oob_q ? OOB_WALLS : ram_q;
    assign qif.r_move_ok = !oob_q && tgt_ok_q && !ram_q[wall_idx(dir_q)];

    assign tile_w      = geo.tile_w;
    assign tile_h      = geo.tile_h;
    assign wall_margin = geo.wall_margin;
    assign num_rows    = geo.num_rows;
    assign num_cols    = geo.num_cols;
endmodule

// File: tb/tb_maze_level_store.sv
// Self-checking bench for maze_level_store: table-driven query vectors with a
// response scoreboard, plus hand-written load, error and reset sequences.
module tb_maze_level_store;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_req = 1'b0;
    logic [1:0] level_sel = '0;
    logic       load_busy, load_done, load_err, level_valid;
    logic [9:0] tile_w, tile_h, wall_margin;
    logic [4:0] num_rows, num_cols;

    maze_level_store_if #(.ROW_W(3), .COL_W(4)) qif ();

    maze_level_store #(.NUM_LEVELS(3), .MAX_ROWS(8), .MAX_COLS(16), .OOB_WALLS(4'b1111)) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .level_sel(level_sel),
        .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
        .level_valid(level_valid), .qif(qif),
        .tile_w(tile_w), .tile_h(tile_h), .wall_margin(wall_margin),
        .num_rows(num_rows), .num_cols(num_cols)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] row;
        logic [3:0] col;
        logic [1:0] dir;
        logic [3:0] walls;
        logic       ok;
    } vec_t;

    typedef struct packed {
        logic [3:0] walls;
        logic       ok;
    } exp_t;

    exp_t sb [$];
    int   n_cmp = 0;
    int   n_fail = 0;
    vec_t l1_tab [14];
    vec_t l2_tab [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int row, input int col, input int dir,
                                input logic [3:0] walls, input logic ok);
        vec_t v;
        v.row = 3'(row); v.col = 4'(col); v.dir = 2'(dir);
        v.walls = walls; v.ok = ok;
        return v;
    endfunction

    // Response monitor: every r_valid must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (qif.r_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_r_valid", 32'(qif.r_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("r_walls", 32'(qif.r_walls), 32'(e.walls));
                    check("r_move_ok", 32'(qif.r_move_ok), 32'(e.ok));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Drives one query for one cycle; callers chain these for back-to-back traffic.
    task automatic query(input vec_t v);
        exp_t e;
        @(negedge clk);
        qif.q_valid = 1'b1;
        qif.q_row   = v.row;
        qif.q_col   = v.col;
        qif.q_dir   = v.dir;
        #1;
        check("q_ready", 32'(qif.q_ready), 32'd1);
        e.walls = v.walls;
        e.ok    = v.ok;
        sb.push_back(e);
    endtask

    task automatic end_queries();
        @(negedge clk);
        qif.q_valid = 1'b0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_load(input logic [1:0] sel);
        int busy;
        @(negedge clk);
        load_req  = 1'b1;
        level_sel = sel;
        @(negedge clk);
        load_req = 1'b0;
        busy = 0;
        while (load_busy && busy < 1000) begin
            busy++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(busy), 32'd128);
        check("load_done_pulse", 32'(load_done), 32'd1);
        check("level_valid_set", 32'(level_valid), 32'd1);
        check("q_ready_in_done", 32'(qif.q_ready), 32'd0);
        @(negedge clk);
        check("load_done_cleared", 32'(load_done), 32'd0);
        check("q_ready_back", 32'(qif.q_ready), 32'd1);
    endtask

    initial begin
        int n;
        l1_tab[0]  = mk(0, 2, 2, 4'b1100, 1'b1);
        l1_tab[1]  = mk(0, 2, 0, 4'b1100, 1'b0);
        l1_tab[2]  = mk(0, 2, 3, 4'b1100, 1'b1);
        l1_tab[3]  = mk(0, 1, 0, 4'b0000, 1'b0);
        l1_tab[4]  = mk(0, 1, 2, 4'b0000, 1'b1);
        l1_tab[5]  = mk(0, 0, 2, 4'b1010, 1'b0);
        l1_tab[6]  = mk(0, 0, 3, 4'b1010, 1'b1);
        l1_tab[7]  = mk(7, 15, 0, 4'b0101, 1'b1);
        l1_tab[8]  = mk(7, 15, 3, 4'b0101, 1'b0);
        l1_tab[9]  = mk(3, 15, 3, 4'b0001, 1'b0);
        l1_tab[10] = mk(1, 1, 1, 4'b0100, 1'b0);
        l1_tab[11] = mk(1, 1, 0, 4'b0100, 1'b1);
        l1_tab[12] = mk(0, 4, 3, 4'b1001, 1'b0);
        l1_tab[13] = mk(4, 5, 1, 4'b0000, 1'b1);

        l2_tab[0] = mk(5, 0, 0, 4'b1111, 1'b0);
        l2_tab[1] = mk(0, 10, 3, 4'b1111, 1'b0);
        l2_tab[2] = mk(4, 9, 0, 4'b0101, 1'b1);
        l2_tab[3] = mk(4, 9, 3, 4'b0101, 1'b0);
        l2_tab[4] = mk(0, 3, 0, 4'b0001, 1'b0);
        l2_tab[5] = mk(0, 3, 2, 4'b0001, 1'b1);
        l2_tab[6] = mk(2, 1, 2, 4'b0000, 1'b1);
        l2_tab[7] = mk(4, 4, 1, 4'b0100, 1'b0);
        l2_tab[8] = mk(4, 4, 3, 4'b0100, 1'b1);
        l2_tab[9] = mk(7, 15, 0, 4'b1111, 1'b0);

        qif.q_valid = 1'b0;
        qif.q_row   = '0;
        qif.q_col   = '0;
        qif.q_dir   = '0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_load_busy", 32'(load_busy), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        check("rst_level_valid", 32'(level_valid), 32'd0);
        check("rst_r_valid", 32'(qif.r_valid), 32'd0);
        check("rst_r_walls", 32'(qif.r_walls), 32'hf);
        check("rst_r_move_ok", 32'(qif.r_move_ok), 32'd0);
        check("rst_geometry", {tile_w, tile_h, wall_margin, num_rows}, 32'd0);
        check("rst_num_cols", 32'(num_cols), 32'd0);

        // Query before any level is loaded.
        query(mk(0, 0, 3, 4'b1111, 1'b0));
        end_queries();

        do_load(2'd1);
        check("l1_num_rows", 32'(num_rows), 32'd8);
        check("l1_num_cols", 32'(num_cols), 32'd16);
        check("l1_tile_w", 32'(tile_w), 32'd20);
        check("l1_tile_h", 32'(tile_h), 32'd30);
        check("l1_wall_margin", 32'(wall_margin), 32'd3);
        for (int i = 0; i < 14; i++) query(l1_tab[i]);
        end_queries();

        // Invalid level: error pulse, no load, previous map kept.
        @(negedge clk);
        load_req  = 1'b1;
        level_sel = 2'd3;
        @(negedge clk);
        load_req = 1'b0;
        check("load_err_pulse", 32'(load_err), 32'd1);
        check("load_err_no_busy", 32'(load_busy), 32'd0);
        @(negedge clk);
        check("load_err_cleared", 32'(load_err), 32'd0);
        check("load_err_no_busy2", 32'(load_busy), 32'd0);
        check("load_err_level_valid", 32'(level_valid), 32'd1);
        query(l1_tab[0]);
        query(l1_tab[7]);
        end_queries();

        do_load(2'd2);
        check("l2_num_rows", 32'(num_rows), 32'd5);
        check("l2_num_cols", 32'(num_cols), 32'd10);
        check("l2_tile_w", 32'(tile_w), 32'd32);
        check("l2_tile_h", 32'(tile_h), 32'd24);
        check("l2_wall_margin", 32'(wall_margin), 32'd4);
        for (int i = 0; i < 10; i++) query(l2_tab[i]);
        end_queries();

        // Reset in the middle of a load.
        @(negedge clk);
        load_req  = 1'b1;
        level_sel = 2'd1;
        @(negedge clk);
        load_req = 1'b0;
        check("level_valid_drop", 32'(level_valid), 32'd0);
        repeat (49) @(negedge clk);
        check("busy_at_50", 32'(load_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 32'(load_busy), 32'd0);
        check("midrst_level_valid", 32'(level_valid), 32'd0);
        check("midrst_num_rows", 32'(num_rows), 32'd0);
        query(mk(0, 2, 2, 4'b1111, 1'b0));
        end_queries();

        // Load and query in the same cycle: the load wins.
        @(negedge clk);
        load_req    = 1'b1;
        level_sel   = 2'd0;
        qif.q_valid = 1'b1;
        qif.q_row   = '0;
        qif.q_col   = '0;
        qif.q_dir   = 2'd3;
        #1;
        check("collide_q_ready", 32'(qif.q_ready), 32'd0);
        @(negedge clk);
        load_req    = 1'b0;
        qif.q_valid = 1'b0;
        check("collide_load_started", 32'(load_busy), 32'd1);
        n = 0;
        while (!load_done && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("collide_load_done", 32'(load_done), 32'd1);
        check("l0_num_cols", 32'(num_cols), 32'd6);
        @(negedge clk);
        query(mk(3, 5, 0, 4'b0101, 1'b1));
        query(mk(4, 0, 0, 4'b1111, 1'b0));
        end_queries();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
